mem_req_arbiter: RTL and testbench

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter_pkg.sv | 21 ++
 rtl/mem_rr_pick.sv | 19 +
 rtl/mem_req_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the memory request arbiter: bus widths, timeout default,
// FSM state encoding and port identifiers.
package mem_req_arbiter_pkg;

  localparam int LC_MEM_ADDR_WIDTH      = 30;
  localparam int LC_MEM_DATA_WIDTH      = 32;
  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } arb_port_e;

endpackage

// File: rtl/mem_rr_pick.sv
// Two-input round-robin picker: a lone requester wins; on a tie the port that
// was not served last wins.
module mem_rr_pick
  import mem_req_arbiter_pkg::*;
(
  input  logic      req_a,
  input  logic      req_b,
  input  arb_port_e last_served,
  output logic      grant_a,
  output logic      grant_b
);

  // Grant A when it is alone or when B had the previous turn; B otherwise.
  always_comb begin
    grant_a = req_a & (~req_b | (last_served == PORT_B));
    grant_b = req_b & ~grant_a;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates two 4-phase request ports (A: layer controller, B: local/debug)
// onto a single 4-phase memory port, with a per-transaction timeout.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                         CLK,
  input  logic                         RESETn,
  input  logic                         REQ_A,
  input  logic                         REQ_B,
  input  logic                         WRITE_A,
  input  logic                         WRITE_B,
  input  logic [LC_MEM_ADDR_WIDTH-1:0] ADDR_A,
  input  logic [LC_MEM_ADDR_WIDTH-1:0] ADDR_B,
  input  logic [LC_MEM_DATA_WIDTH-1:0] WDATA_A,
  input  logic [LC_MEM_DATA_WIDTH-1:0] WDATA_B,
  output logic                         ACK_A,
  output logic                         ACK_B,
  output logic                         ERR_A,
  output logic                         ERR_B,
  output logic [LC_MEM_DATA_WIDTH-1:0] RDATA,
  output logic                         MEM_REQ,
  output logic                         MEM_WRITE,
  output logic [LC_MEM_ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [LC_MEM_DATA_WIDTH-1:0] MEM_DATA_IN,
  input  logic                         MEM_ACK_IN,
  input  logic [LC_MEM_DATA_WIDTH-1:0] MEM_DATA_OUT
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  arb_state_e                   state, state_nxt;
  arb_port_e                    winner, winner_nxt;
  arb_port_e                    last_served, last_served_nxt;
  logic [15:0]                  timeout_cnt, timeout_cnt_nxt;
  logic                         drain_pending, drain_pending_nxt;
  logic                         ack_a_nxt, ack_b_nxt, err_a_nxt, err_b_nxt;
  logic [LC_MEM_DATA_WIDTH-1:0] rdata_nxt;
  logic                         mem_req_nxt, mem_write_nxt;
  logic [LC_MEM_ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [LC_MEM_DATA_WIDTH-1:0] mem_data_in_nxt;
  logic                         grant_a, grant_b;
  logic                         winner_req;

  mem_rr_pick u_pick (
    .req_a       (REQ_A),
    .req_b       (REQ_B),
    .last_served (last_served),
    .grant_a     (grant_a),
    .grant_b     (grant_b)
  );

  // State and output registers; reset abandons any transaction and forces one
  // trip through DRAIN so a memory ack left over from before reset is consumed.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state         <= ST_IDLE;
      winner        <= PORT_A;
      last_served   <= PORT_B;
      timeout_cnt   <= '0;
      drain_pending <= 1'b1;
      ACK_A         <= 1'b0;
      ACK_B         <= 1'b0;
      ERR_A         <= 1'b0;
      ERR_B         <= 1'b0;
      RDATA         <= '0;
      MEM_REQ       <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDR      <= '0;
      MEM_DATA_IN   <= '0;
    end else begin
      state         <= state_nxt;
      winner        <= winner_nxt;
      last_served   <= last_served_nxt;
      timeout_cnt   <= timeout_cnt_nxt;
      drain_pending <= drain_pending_nxt;
      ACK_A         <= ack_a_nxt;
      ACK_B         <= ack_b_nxt;
      ERR_A         <= err_a_nxt;
      ERR_B         <= err_b_nxt;
      RDATA         <= rdata_nxt;
      MEM_REQ       <= mem_req_nxt;
      MEM_WRITE     <= mem_write_nxt;
      MEM_ADDR      <= mem_addr_nxt;
      MEM_DATA_IN   <= mem_data_in_nxt;
    end
  end

  // Next-state and next-output logic; everything holds unless a state acts on it.
  always_comb begin
    state_nxt         = state;
    winner_nxt        = winner;
    last_served_nxt   = last_served;
    drain_pending_nxt = drain_pending;
    ack_a_nxt         = ACK_A;
    ack_b_nxt         = ACK_B;
    err_a_nxt         = ERR_A;
    err_b_nxt         = ERR_B;
    rdata_nxt         = RDATA;
    mem_req_nxt       = MEM_REQ;
    mem_write_nxt     = MEM_WRITE;
    mem_addr_nxt      = MEM_ADDR;
    mem_data_in_nxt   = MEM_DATA_IN;
    timeout_cnt_nxt   = timeout_cnt;
    winner_req        = (winner == PORT_B) ? REQ_B : REQ_A;

    if ((state == ST_GRANT) && (timeout_cnt != 16'hFFFF)) begin
      timeout_cnt_nxt = timeout_cnt + 16'd1;
    end

    case (state)
      ST_IDLE: begin
        if (drain_pending) begin
          drain_pending_nxt = 1'b0;
          state_nxt         = ST_DRAIN;
        end else if (grant_a || grant_b) begin
          state_nxt       = ST_GRANT;
          winner_nxt      = grant_b ? PORT_B : PORT_A;
          mem_req_nxt     = 1'b1;
          mem_write_nxt   = grant_b ? WRITE_B : WRITE_A;
          mem_addr_nxt    = grant_b ? ADDR_B : ADDR_A;
          mem_data_in_nxt = grant_b ? WDATA_B : WDATA_A;
          timeout_cnt_nxt = '0;
        end
      end

      ST_GRANT: begin
        if (MEM_ACK_IN) begin
          if (!MEM_WRITE) begin
            rdata_nxt = MEM_DATA_OUT;
          end
          if (winner_req) begin
            ack_a_nxt = (winner == PORT_A);
            ack_b_nxt = (winner == PORT_B);
            err_a_nxt = 1'b0;
            err_b_nxt = 1'b0;
            state_nxt = ST_RESP;
          end else begin
            mem_req_nxt     = 1'b0;
            last_served_nxt = winner;
            state_nxt       = ST_DRAIN;
          end
        end else if (timeout_cnt == TIMEOUT_LAST) begin
          mem_req_nxt = 1'b0;
          if (winner_req) begin
            rdata_nxt = '0;
            ack_a_nxt = (winner == PORT_A);
            ack_b_nxt = (winner == PORT_B);
            err_a_nxt = (winner == PORT_A);
            err_b_nxt = (winner == PORT_B);
            state_nxt = ST_RESP;
          end else begin
            last_served_nxt = winner;
            state_nxt       = ST_DRAIN;
          end
        end
      end

      ST_RESP: begin
        if (!winner_req) begin
          ack_a_nxt       = 1'b0;
          ack_b_nxt       = 1'b0;
          err_a_nxt       = 1'b0;
          err_b_nxt       = 1'b0;
          mem_req_nxt     = 1'b0;
          last_served_nxt = winner;
          state_nxt       = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (!MEM_ACK_IN) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a small 4-phase memory model that
// acks in-range addresses (below 0x100) after a short latency.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  localparam int AW      = LC_MEM_ADDR_WIDTH;
  localparam int DW      = LC_MEM_DATA_WIDTH;
  localparam int MEM_LAT = 1;

  logic          CLK          = 1'b0;
  logic          RESETn       = 1'b0;
  logic          REQ_A        = 1'b0;
  logic          REQ_B        = 1'b0;
  logic          WRITE_A      = 1'b0;
  logic          WRITE_B      = 1'b0;
  logic [AW-1:0] ADDR_A       = '0;
  logic [AW-1:0] ADDR_B       = '0;
  logic [DW-1:0] WDATA_A      = '0;
  logic [DW-1:0] WDATA_B      = '0;
  logic          MEM_ACK_IN   = 1'b0;
  logic [DW-1:0] MEM_DATA_OUT = '0;
  logic          ACK_A, ACK_B, ERR_A, ERR_B;
  logic [DW-1:0] RDATA;
  logic          MEM_REQ, MEM_WRITE;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_DATA_IN;

  int checks = 0;
  int failures = 0;
  int ack_a_count = 0;
  int both_count = 0;
  int lat_cnt = 0;
  bit mem_hold_ack = 1'b0;
  logic [DW-1:0] mem [256];
  bit written [256];

  mem_req_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .CLK          (CLK),
    .RESETn       (RESETn),
    .REQ_A        (REQ_A),
    .REQ_B        (REQ_B),
    .WRITE_A      (WRITE_A),
    .WRITE_B      (WRITE_B),
    .ADDR_A       (ADDR_A),
    .ADDR_B       (ADDR_B),
    .WDATA_A      (WDATA_A),
    .WDATA_B      (WDATA_B),
    .ACK_A        (ACK_A),
    .ACK_B        (ACK_B),
    .ERR_A        (ERR_A),
    .ERR_B        (ERR_B),
    .RDATA        (RDATA),
    .MEM_REQ      (MEM_REQ),
    .MEM_WRITE    (MEM_WRITE),
    .MEM_ADDR     (MEM_ADDR),
    .MEM_DATA_IN  (MEM_DATA_IN),
    .MEM_ACK_IN   (MEM_ACK_IN),
    .MEM_DATA_OUT (MEM_DATA_OUT)
  );

  // Free-running clock, period 10.
  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] presetWord(input logic [7:0] a);
    case (a)
      8'h10:   presetWord = 32'hDEADBEEF;
      8'h30:   presetWord = 32'hA5A50030;
      8'h40:   presetWord = 32'h5A5A0040;
      default: presetWord = 32'h0;
    endcase
  endfunction

  // Memory model: acks in-range requests after MEM_LAT idle negedges, drops ack
  // once MEM_REQ falls; mem_hold_ack pins ack high to mimic a stuck response.
  always @(negedge CLK) begin
    if (mem_hold_ack) begin
      MEM_ACK_IN = 1'b1;
    end else if (MEM_REQ && !MEM_ACK_IN) begin
      if (MEM_ADDR < 30'h100) begin
        if (lat_cnt >= MEM_LAT) begin
          if (MEM_WRITE) begin
            mem[MEM_ADDR[7:0]]     = MEM_DATA_IN;
            written[MEM_ADDR[7:0]] = 1'b1;
          end
          MEM_DATA_OUT = written[MEM_ADDR[7:0]] ? mem[MEM_ADDR[7:0]] : presetWord(MEM_ADDR[7:0]);
          MEM_ACK_IN   = 1'b1;
          lat_cnt      = 0;
        end else begin
          lat_cnt++;
        end
      end
    end else if (!MEM_REQ) begin
      MEM_ACK_IN = 1'b0;
      lat_cnt    = 0;
    end
  end

  // Acknowledge monitor: counts port A acks and any cycle with both acks high.
  always @(negedge CLK) begin
    if (ACK_A === 1'b1) ack_a_count++;
    if ((ACK_A === 1'b1) && (ACK_B === 1'b1)) both_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit port_b, input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (port_b) begin
      WRITE_B = wr; ADDR_B = addr; WDATA_B = wdata; REQ_B = 1'b1;
    end else begin
      WRITE_A = wr; ADDR_A = addr; WDATA_A = wdata; REQ_A = 1'b1;
    end
  endtask

  task automatic dropReq(input bit port_b);
    if (port_b) REQ_B = 1'b0;
    else        REQ_A = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic waitAck(input bit port_b, input int limit);
    int n = 0;
    while (((port_b ? ACK_B : ACK_A) !== 1'b1) && (n < limit)) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic waitEither(input int limit);
    int n = 0;
    while ((ACK_A !== 1'b1) && (ACK_B !== 1'b1) && (n < limit)) begin
      @(negedge CLK);
      n++;
    end
  endtask

  initial begin
    int ack_a_base;
    bit exp_b;
    bit got_b;

    // Reset state
    @(negedge CLK);
    checkOutput("reset_ack_a", ACK_A, 1'b0);
    checkOutput("reset_ack_b", ACK_B, 1'b0);
    checkOutput("reset_mem_req", MEM_REQ, 1'b0);
    checkOutput("reset_rdata", RDATA, 32'h0);
    RESETn = 1'b1;
    cycles(4);

    // Single read on port A; port inputs changed after grant must not leak through
    $display("[TB] single read on port A");
    applyStimulus(1'b0, 1'b0, 30'h10, 32'h0);
    @(negedge CLK);
    checkOutput("rd_mem_req_rise", MEM_REQ, 1'b1);
    checkOutput("rd_mem_addr", MEM_ADDR, 32'h10);
    checkOutput("rd_mem_write", MEM_WRITE, 1'b0);
    ADDR_A = 30'h55;
    waitAck(1'b0, 20);
    checkOutput("rd_ack_a", ACK_A, 1'b1);
    checkOutput("rd_err_a", ERR_A, 1'b0);
    checkOutput("rd_rdata", RDATA, 32'hDEADBEEF);
    checkOutput("rd_addr_stable", MEM_ADDR, 32'h10);
    checkOutput("rd_ack_b_low", ACK_B, 1'b0);
    dropReq(1'b0);
    @(negedge CLK);
    checkOutput("rd_ack_a_fall", ACK_A, 1'b0);
    checkOutput("rd_mem_req_fall", MEM_REQ, 1'b0);
    cycles(4);

    // Write then readback on port B
    $display("[TB] write and readback on port B");
    ack_a_base = ack_a_count;
    applyStimulus(1'b1, 1'b1, 30'h20, 32'h12345678);
    waitAck(1'b1, 20);
    checkOutput("wr_ack_b", ACK_B, 1'b1);
    checkOutput("wr_err_b", ERR_B, 1'b0);
    checkOutput("wr_rdata_hold", RDATA, 32'hDEADBEEF);
    dropReq(1'b1);
    @(negedge CLK);
    checkOutput("wr_ack_b_fall", ACK_B, 1'b0);
    cycles(4);
    applyStimulus(1'b1, 1'b0, 30'h20, 32'h0);
    waitAck(1'b1, 20);
    checkOutput("rb_ack_b", ACK_B, 1'b1);
    checkOutput("rb_rdata", RDATA, 32'h12345678);
    dropReq(1'b1);
    cycles(4);
    checkOutput("rb_no_ack_a", ack_a_count - ack_a_base, 32'd0);

    // Round robin from reset with both ports requesting
    $display("[TB] round robin from reset");
    RESETn = 1'b0;
    applyStimulus(1'b0, 1'b0, 30'h30, 32'h0);
    applyStimulus(1'b1, 1'b0, 30'h40, 32'h0);
    @(negedge CLK);
    RESETn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_b = (k % 2) == 1;
      waitEither(30);
      checkOutput($sformatf("rr_grant_b_%0d", k), ACK_B, exp_b);
      checkOutput($sformatf("rr_rdata_%0d", k), RDATA, exp_b ? 32'h5A5A0040 : 32'hA5A50030);
      got_b = (ACK_B === 1'b1);
      dropReq(got_b);
      @(negedge CLK);
      applyStimulus(got_b, 1'b0, got_b ? 30'h40 : 30'h30, 32'h0);
    end
    dropReq(1'b0);
    dropReq(1'b1);
    cycles(6);

    // Timeout on an address the memory never answers
    $display("[TB] timeout on port A");
    applyStimulus(1'b0, 1'b0, 30'h10000, 32'h0);
    @(negedge CLK);
    checkOutput("to_mem_req_rise", MEM_REQ, 1'b1);
    cycles(7);
    checkOutput("to_ack_a_early", ACK_A, 1'b0);
    checkOutput("to_mem_req_held", MEM_REQ, 1'b1);
    @(negedge CLK);
    checkOutput("to_ack_a", ACK_A, 1'b1);
    checkOutput("to_err_a", ERR_A, 1'b1);
    checkOutput("to_rdata_zero", RDATA, 32'h0);
    checkOutput("to_mem_req_fall", MEM_REQ, 1'b0);
    dropReq(1'b0);
    @(negedge CLK);
    checkOutput("to_ack_a_fall", ACK_A, 1'b0);
    checkOutput("to_err_a_fall", ERR_A, 1'b0);
    cycles(4);

    // Reset during GRANT with the memory ack stuck high afterwards
    $display("[TB] reset mid-transaction");
    applyStimulus(1'b0, 1'b0, 30'h10001, 32'h0);
    @(negedge CLK);
    checkOutput("rst_mem_req_before", MEM_REQ, 1'b1);
    @(negedge CLK);
    RESETn = 1'b0;
    mem_hold_ack = 1'b1;
    #1;
    checkOutput("rst_mem_req", MEM_REQ, 1'b0);
    checkOutput("rst_mem_addr", MEM_ADDR, 32'h0);
    checkOutput("rst_ack_a", ACK_A, 1'b0);
    dropReq(1'b0);
    applyStimulus(1'b1, 1'b0, 30'h20, 32'h0);
    cycles(2);
    RESETn = 1'b1;
    cycles(5);
    checkOutput("rst_wait_mem_req", MEM_REQ, 1'b0);
    checkOutput("rst_wait_ack_b", ACK_B, 1'b0);
    mem_hold_ack = 1'b0;
    waitAck(1'b1, 20);
    checkOutput("rst_ack_b", ACK_B, 1'b1);
    checkOutput("rst_err_b", ERR_B, 1'b0);
    checkOutput("rst_rdata", RDATA, 32'h12345678);
    dropReq(1'b1);
    @(negedge CLK);
    checkOutput("rst_ack_b_fall", ACK_B, 1'b0);
    cycles(3);

    checkOutput("ack_one_hot", both_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
